// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - round-robin capture scheduler and frame timer for the scan serializer (optional SCAN_CTRL_AUTO_EN)
module scan_ctrl #(
  parameter int N_REQ       = 4,
  parameter int FRAME_LEN   = 19,
  parameter int GAP_CYCLES  = 2,
  parameter int AUTO_PERIOD = 1000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              ctrl_en,
  input  logic [N_REQ-1:0]                                  req,
  input  logic                                              abort,
  input  logic                                              clr_ovr,
  output logic                                              scan_en,
  output logic [(($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1)-1:0] scan_sel,
  output logic [N_REQ-1:0]                                  ack,
  output logic                                              frame_start,
  output logic                                              frame_valid,
  output logic                                              frame_aborted,
  output logic                                              busy,
  output logic [N_REQ-1:0]                                  overrun
);

  localparam int SEL_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int GAP_W = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  // LOAD raises scan_en; the serializer registers its enable, so its capture
  // edge falls at the end of CAPT and bit 0 appears in the first SHIFT cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             state;
  logic [N_REQ-1:0]   pending;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [N_REQ-1:0]   req_eff;
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic               grant;
  logic [N_REQ-1:0]   grant_vec;
  logic [N_REQ-1:0]   ovr_set;
  logic [SEL_W-1:0]   next_ptr;

`ifdef SCAN_CTRL_AUTO_EN
  localparam int AP_W = ($clog2(AUTO_PERIOD) > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AP_W-1:0] auto_cnt;
  logic            auto_tick;

  assign auto_tick = ctrl_en && (auto_cnt == AP_W'(AUTO_PERIOD - 1));
  assign req_eff   = req | {{(N_REQ-1){1'b0}}, auto_tick};

  // Free-running auto-capture timer, parked at zero while the block is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!ctrl_en || auto_tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  logic unused_auto;

  assign unused_auto = (AUTO_PERIOD != 0);
  assign req_eff     = req;
`endif

  // Round-robin search over pending sources starting at rr_ptr
  always_comb begin
    logic [SEL_W:0] j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (j >= (SEL_W+1)'(N_REQ)) begin
        j = j - (SEL_W+1)'(N_REQ);
      end
      if (!win_found && pending[j[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[SEL_W-1:0];
      end
    end
  end

  assign grant     = (state == S_IDLE) && ctrl_en && win_found;
  assign grant_vec = grant ? (N_REQ'(1) << win_idx) : '0;
  assign ovr_set   = req_eff & pending & ~grant_vec;
  assign next_ptr  = (win_idx == SEL_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy      = (state != S_IDLE);

  // Pending and sticky overrun bookkeeping; a same-cycle request re-arms a granted source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~grant_vec) | req_eff;
      overrun <= (overrun & {N_REQ{~clr_ovr}}) | ovr_set;
    end
  end

  // Frame sequencer: grant, capture, shift, then enforced enable-low gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      scan_en       <= 1'b0;
      scan_sel      <= '0;
      ack           <= '0;
      frame_start   <= 1'b0;
      frame_valid   <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      ack           <= '0;
      frame_start   <= 1'b0;
      frame_aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state    <= S_LOAD;
            scan_en  <= 1'b1;
            scan_sel <= win_idx;
            ack      <= grant_vec;
            rr_ptr   <= next_ptr;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state         <= S_GAP;
            scan_en       <= 1'b0;
            frame_valid   <= 1'b0;
            frame_aborted <= 1'b1;
            gap_cnt       <= '0;
          end else begin
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (abort) begin
            state         <= S_GAP;
            scan_en       <= 1'b0;
            frame_valid   <= 1'b0;
            frame_aborted <= 1'b1;
            gap_cnt       <= '0;
          end else begin
            state       <= S_SHIFT;
            frame_valid <= 1'b1;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state         <= S_GAP;
            scan_en       <= 1'b0;
            frame_valid   <= 1'b0;
            frame_aborted <= 1'b1;
            gap_cnt       <= '0;
          end else if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
            state       <= S_GAP;
            frame_valid <= 1'b0;
            scan_en     <= 1'b0;
            gap_cnt     <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          scan_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - scoreboard bench for scan_ctrl
module tb_scan_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ctrl_en = 1'b1;
  logic [N-1:0] req = '0;
  logic         abort = 1'b0;
  logic         clr_ovr = 1'b0;
  logic         scan_en;
  logic [1:0]   scan_sel;
  logic [N-1:0] ack;
  logic         frame_start;
  logic         frame_valid;
  logic         frame_aborted;
  logic         busy;
  logic [N-1:0] overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N-1:0] exp_ack[$];
  logic [N-1:0] obs_ack[$];
  int           ack_cyc[$];
  int           fs_cyc[$];
  logic [1:0]   fs_sel[$];

  scan_ctrl #(
    .N_REQ(4), .FRAME_LEN(19), .GAP_CYCLES(2), .AUTO_PERIOD(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .req(req), .abort(abort),
    .clr_ovr(clr_ovr), .scan_en(scan_en), .scan_sel(scan_sel), .ack(ack),
    .frame_start(frame_start), .frame_valid(frame_valid),
    .frame_aborted(frame_aborted), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack != '0) begin
        obs_ack.push_back(ack);
        ack_cyc.push_back(cyc);
      end
      if (frame_start) begin
        fs_cyc.push_back(cyc);
        fs_sel.push_back(scan_sel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fs_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (fs_cyc.size() >= n) ok = 1'b1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; req = '0; abort = 1'b0; clr_ovr = 1'b0; ctrl_en = 1'b1;
    exp_ack.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    step();
    rst_n = 1'b0; req = '0; ctrl_en = 1'b1;
    #1;
    outs = {scan_en, scan_sel, ack, frame_start, frame_valid, frame_aborted, busy, overrun};
    checks++;
    if (outs !== 15'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", outs);
    end
    step();
    rst_n = 1'b1;
    step(); step();
    outs = {scan_en, scan_sel, ack, frame_start, frame_valid, frame_aborted, busy, overrun};
    checks++;
    if (outs !== 15'd0) begin
      errors++; $display("FAIL post_reset_idle: got %b want 0", outs);
    end
  endtask

  task automatic test_single();
    int ab, fb, t0, fv, gl, selbad;
    logic [N-1:0] e;
    do_reset();
    ab = obs_ack.size(); fb = fs_cyc.size();
    t0 = cyc;
    req = 4'b0010; exp_ack.push_back(4'b0010);
    step();
    req = '0;
    fv = 0; gl = 0; selbad = 0;
    for (int i = 0; i < 60; i++) begin
      if (frame_valid) fv++;
      if (busy && !scan_en) gl++;
      if (scan_en && scan_sel !== 2'd1) selbad++;
      step();
    end
    checks++;
    if (ack_cyc.size() <= ab || ack_cyc[ab] - t0 != 2) begin
      errors++; $display("FAIL single_ack_latency: got %0d want 2", (ack_cyc.size() > ab) ? ack_cyc[ab] - t0 : -1);
    end
    checks++;
    if (fs_cyc.size() <= fb || fs_cyc[fb] - t0 != 4) begin
      errors++; $display("FAIL single_fs_latency: got %0d want 4", (fs_cyc.size() > fb) ? fs_cyc[fb] - t0 : -1);
    end
    checks++;
    if (fs_sel.size() <= fb || fs_sel[fb] !== 2'd1) begin
      errors++; $display("FAIL single_scan_sel: got %0d want 1", (fs_sel.size() > fb) ? fs_sel[fb] : 2'd0);
    end
    checks++;
    if (fv != 19 || selbad != 0) begin
      errors++; $display("FAIL single_frame_valid_len: got %0d (sel errors %0d) want 19", fv, selbad);
    end
    checks++;
    if (gl != 2) begin
      errors++; $display("FAIL single_gap_len: got %0d want 2", gl);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_end_idle: busy=%b want 0", busy);
    end
    checks++;
    if (obs_ack.size() - ab != exp_ack.size()) begin
      errors++; $display("FAIL single_ack_count: got %0d want %0d", obs_ack.size() - ab, exp_ack.size());
    end
    for (int k = 0; exp_ack.size() > 0; k++) begin
      e = exp_ack.pop_front();
      if (ab + k < obs_ack.size()) begin
        checks++;
        if (obs_ack[ab+k] !== e) begin
          errors++; $display("FAIL single_ack_sb: got %b want %b", obs_ack[ab+k], e);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int ab, fb;
    bit ok;
    logic [N-1:0] e;
    do_reset();
    ab = obs_ack.size(); fb = fs_cyc.size();
    req = 4'b1111;
    exp_ack.push_back(4'b0001); exp_ack.push_back(4'b0010);
    exp_ack.push_back(4'b0100); exp_ack.push_back(4'b1000);
    step();
    req = '0;
    wait_fs(fb + 4, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_timeout: frames=%0d want 4", fs_cyc.size() - fb);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (fs_cyc[fb+k] - fs_cyc[fb+k-1] != 24) begin
          errors++; $display("FAIL rr_period%0d: got %0d want 24", k, fs_cyc[fb+k] - fs_cyc[fb+k-1]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (fs_sel[fb+k] !== 2'(k)) begin
          errors++; $display("FAIL rr_sel%0d: got %0d want %0d", k, fs_sel[fb+k], k);
        end
      end
    end
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (obs_ack.size() - ab != exp_ack.size()) begin
      errors++; $display("FAIL rr_ack_count: got %0d want %0d", obs_ack.size() - ab, exp_ack.size());
    end
    for (int k = 0; exp_ack.size() > 0; k++) begin
      e = exp_ack.pop_front();
      if (ab + k < obs_ack.size()) begin
        checks++;
        if (obs_ack[ab+k] !== e) begin
          errors++; $display("FAIL rr_ack_sb%0d: got %b want %b", k, obs_ack[ab+k], e);
        end
      end
    end
  endtask

  task automatic test_abort();
    int ab, fb, fv, nab;
    bit ok;
    logic [N-1:0] e;
    do_reset();
    ab = obs_ack.size(); fb = fs_cyc.size();
    req = 4'b0001; exp_ack.push_back(4'b0001);
    step();
    req = 4'b0100; exp_ack.push_back(4'b0100);
    step();
    req = '0;
    wait_fs(fb + 1, 50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL abort_timeout: no frame_start");
    end
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({frame_valid, frame_aborted, scan_en, busy} !== 4'b0101) begin
      errors++; $display("FAIL abort_edge: got fv/fa/en/busy=%b want 0101", {frame_valid, frame_aborted, scan_en, busy});
    end
    step();
    checks++;
    if ({frame_aborted, scan_en, busy} !== 3'b001) begin
      errors++; $display("FAIL abort_gap2: got fa/en/busy=%b want 001", {frame_aborted, scan_en, busy});
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_gap_end: busy=%b want 0", busy);
    end
    step();
    checks++;
    if ({ack, scan_en} !== 5'b0100_1) begin
      errors++; $display("FAIL abort_next_grant: got ack/en=%b want 01001", {ack, scan_en});
    end
    fv = 0; nab = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_valid) fv++;
      if (frame_aborted) nab++;
    end
    checks++;
    if (fv != 19 || nab != 0) begin
      errors++; $display("FAIL abort_followup_frame: got valid=%0d aborts=%0d want 19 0", fv, nab);
    end
    checks++;
    if (obs_ack.size() - ab != exp_ack.size()) begin
      errors++; $display("FAIL abort_ack_count: got %0d want %0d", obs_ack.size() - ab, exp_ack.size());
    end
    for (int k = 0; exp_ack.size() > 0; k++) begin
      e = exp_ack.pop_front();
      if (ab + k < obs_ack.size()) begin
        checks++;
        if (obs_ack[ab+k] !== e) begin
          errors++; $display("FAIL abort_ack_sb%0d: got %b want %b", k, obs_ack[ab+k], e);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int ab, fb;
    bit ok;
    logic [N-1:0] e;
    do_reset();
    ab = obs_ack.size(); fb = fs_cyc.size();
    req = 4'b0001; exp_ack.push_back(4'b0001);
    step();
    req = '0;
    wait_fs(fb + 1, 50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ovr_timeout: no frame_start");
    end
    req = 4'b1000; exp_ack.push_back(4'b1000);
    step();
    req = '0;
    step();
    checks++;
    if (overrun !== 4'b0000) begin
      errors++; $display("FAIL ovr_first_req: got %b want 0000", overrun);
    end
    req = 4'b1000;
    step();
    req = '0;
    checks++;
    if (overrun !== 4'b1000) begin
      errors++; $display("FAIL ovr_set: got %b want 1000", overrun);
    end
    for (int i = 0; i < 60; i++) step();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 4'b0000) begin
      errors++; $display("FAIL ovr_clear: got %b want 0000", overrun);
    end
    ctrl_en = 1'b0;
    req = 4'b1000;
    step();
    clr_ovr = 1'b1;
    step();
    req = '0; clr_ovr = 1'b0;
    checks++;
    if (overrun !== 4'b1000) begin
      errors++; $display("FAIL ovr_set_wins: got %b want 1000", overrun);
    end
    ctrl_en = 1'b1; exp_ack.push_back(4'b1000);
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (obs_ack.size() - ab != exp_ack.size()) begin
      errors++; $display("FAIL ovr_ack_count: got %0d want %0d", obs_ack.size() - ab, exp_ack.size());
    end
    for (int k = 0; exp_ack.size() > 0; k++) begin
      e = exp_ack.pop_front();
      if (ab + k < obs_ack.size()) begin
        checks++;
        if (obs_ack[ab+k] !== e) begin
          errors++; $display("FAIL ovr_ack_sb%0d: got %b want %b", k, obs_ack[ab+k], e);
        end
      end
    end
  endtask

  task automatic test_ctrl_en();
    int ab, bad;
    logic [N-1:0] e;
    do_reset();
    ab = obs_ack.size();
    ctrl_en = 1'b0;
    req = 4'b0101;
    step();
    req = '0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ack !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ctrl_en_hold: %0d active cycles want 0", bad);
    end
    ctrl_en = 1'b1;
    exp_ack.push_back(4'b0001); exp_ack.push_back(4'b0100);
    step();
    checks++;
    if (ack !== 4'b0001) begin
      errors++; $display("FAIL ctrl_en_release: ack=%b want 0001", ack);
    end
    for (int i = 0; i < 60; i++) step();
    checks++;
    if (obs_ack.size() - ab != exp_ack.size()) begin
      errors++; $display("FAIL ctrl_en_ack_count: got %0d want %0d", obs_ack.size() - ab, exp_ack.size());
    end
    for (int k = 0; exp_ack.size() > 0; k++) begin
      e = exp_ack.pop_front();
      if (ab + k < obs_ack.size()) begin
        checks++;
        if (obs_ack[ab+k] !== e) begin
          errors++; $display("FAIL ctrl_en_ack_sb%0d: got %b want %b", k, obs_ack[ab+k], e);
        end
      end
    end
  endtask

  task automatic test_auto();
    int ab;
    do_reset();
    ab = obs_ack.size();
    ctrl_en = 1'b1;
    for (int i = 0; i < 350; i++) step();
`ifdef SCAN_CTRL_AUTO_EN
    checks++;
    if (obs_ack.size() - ab != 3) begin
      errors++; $display("FAIL auto_ack_count: got %0d want 3", obs_ack.size() - ab);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (ack_cyc[ab+k] - ack_cyc[ab+k-1] != 100 || obs_ack[ab+k] !== 4'b0001) begin
          errors++; $display("FAIL auto_period%0d: got %0d want 100", k, ack_cyc[ab+k] - ack_cyc[ab+k-1]);
        end
      end
    end
`else
    checks++;
    if (obs_ack.size() != ab || busy !== 1'b0) begin
      errors++; $display("FAIL auto_disabled: got %0d acks want 0", obs_ack.size() - ab);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_overrun();
    test_ctrl_en();
    test_auto();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
